// File: rtl/useq_arith_unit.sv
// Multi-cycle unsigned arithmetic unit: single-cycle add/sub, iterative shift-add multiply
// and restoring divide, launched by a start/busy/done handshake.
module useq_arith_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] answer,
    output logic [WIDTH-1:0] answer_hi,
    output logic             carry,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  hi_q, lo_q, opb_q;
    logic              is_div_q;
    logic              accept, launch_iter, last_iter;

    logic [WIDTH-1:0]  done_q_unused_guard;
    logic              done_q, carry_q, div_zero_q;
    logic [WIDTH-1:0]  answer_q, answer_hi_q;

    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_trial;
    logic [WIDTH-1:0]  hi_nx, lo_nx;

    assign accept      = (state_q == StIdle) && start;
    // Only MUL and DIV with a non-zero divisor need the iterative datapath.
    assign launch_iter = accept && op_code[1] && !(op_code[0] && (b == '0));
    assign last_iter   = (state_q == StRun) && (cnt_q == CntW'(1));
    assign done_q_unused_guard = '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (launch_iter) state_d = StRun;
            StRun:  if (last_iter)   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q == StRun);
        done      = done_q;
        answer    = answer_q | done_q_unused_guard;
        answer_hi = answer_hi_q;
        carry     = carry_q;
        div_zero  = div_zero_q;
    end

    // One iteration step; hi_q/lo_q hold {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        add_sum   = {1'b0, a} + {1'b0, b};
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
        hi_nx     = '0;
        lo_nx     = '0;
        if (is_div_q) begin
            if (div_trial[WIDTH]) begin
                hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_nx = div_trial[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            done_q      <= 1'b0;
            answer_q    <= '0;
            answer_hi_q <= '0;
            carry_q     <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (op_code == OpAdd) begin
                    answer_q    <= add_sum[WIDTH-1:0];
                    answer_hi_q <= '0;
                    carry_q     <= add_sum[WIDTH];
                    div_zero_q  <= 1'b0;
                    done_q      <= 1'b1;
                end else if (op_code == OpSub) begin
                    answer_q    <= a - b;
                    answer_hi_q <= '0;
                    carry_q     <= (a < b);
                    div_zero_q  <= 1'b0;
                    done_q      <= 1'b1;
                end else if (!launch_iter) begin
                    answer_q    <= '1;
                    answer_hi_q <= a;
                    carry_q     <= 1'b0;
                    div_zero_q  <= 1'b1;
                    done_q      <= 1'b1;
                end else begin
                    cnt_q    <= CntW'(WIDTH);
                    is_div_q <= (op_code != OpMul);
                    hi_q     <= '0;
                    lo_q     <= (op_code == OpMul) ? b : a;
                    opb_q    <= (op_code == OpMul) ? a : b;
                end
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q - CntW'(1);
                hi_q  <= hi_nx;
                lo_q  <= lo_nx;
                if (last_iter) begin
                    answer_q    <= lo_nx;
                    answer_hi_q <= hi_nx;
                    carry_q     <= 1'b0;
                    div_zero_q  <= 1'b0;
                    done_q      <= 1'b1;
                end
            end
        end
    end

endmodule
